// File: rtl/wire_cut_pkg.sv
// Shared types and helpers for the wire-cut puzzle checker.
package wire_cut_pkg;

    // Round controller states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SOLVED   = 2'd2,
        ST_EXPLODED = 2'd3
    } state_e;

    // Widest supported wire bundle and a count width that can hold
    // (max strikes + max simultaneous bad cuts) = 15 + 16 = 31.
    localparam int MAX_WIRES = 16;
    localparam int PW        = 5;

    // Number of set bits in a (zero-extended) wire vector.
    function automatic logic [PW-1:0] popcount(input logic [MAX_WIRES-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIRES; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/wire_cut_checker_debouncer.sv
// One wire: 2-flop synchroniser followed by a stable-count debouncer.
// The debounced value follows the synchronised value only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts.
module wire_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic wire_i,
    output logic debounced_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive disagreeing cycles; flip once the run is long enough.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; reset to "wire intact".
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking (<=) so every flop samples pre-edge values;
        // blocking here would collapse the synchroniser into one stage.
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= wire_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign debounced_o = deb_q;

endmodule

// File: rtl/wire_cut_checker.sv
// Wire-puzzle round controller: scores each newly cut wire as a required
// cut or a strike, and reports solved / exploded.
module wire_cut_checker
    import wire_cut_pkg::*;
#(
    parameter  int N_WIRES         = 6,
    parameter  int MAX_STRIKES     = 3,
    parameter  int DEBOUNCE_CYCLES = 100000,
    localparam int SW              = $clog2(MAX_STRIKES + 1)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N_WIRES-1:0] wire_in,
    input  logic [N_WIRES-1:0] target_mask,
    input  logic               arm,
    output logic               led_solved,
    output logic               led_exploded,
    output logic [SW-1:0]      strikes,
    output logic               cut_pulse,
    output logic [N_WIRES-1:0] cut_mask
);

    localparam logic [SW-1:0] STRIKE_LIMIT = SW'(MAX_STRIKES);

    logic [N_WIRES-1:0]   debounced;

    state_e               state_q,     state_d;
    logic [SW-1:0]        strikes_q,   strikes_d;
    logic [N_WIRES-1:0]   cut_mask_q,  cut_mask_d;
    logic [N_WIRES-1:0]   target_q,    target_d;
    logic                 cut_pulse_q, cut_pulse_d;
    logic                 solved_q;
    logic                 exploded_q;

    logic [N_WIRES-1:0]   new_cuts;
    logic [MAX_WIRES-1:0] bad_wide;
    logic [PW-1:0]        strike_sum;

    for (genvar i = 0; i < N_WIRES; i++) begin : g_deb
        wire_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .CLK         (CLK),
            .RESET       (RESET),
            .wire_i      (wire_in[i]),
            .debounced_o (debounced[i])
        );
    end

    // Next-state logic: arm restarts from any state; cuts scored only while armed.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        strikes_d   = strikes_q;
        cut_mask_d  = cut_mask_q;
        target_d    = target_q;
        cut_pulse_d = 1'b0;

        // A new cut is a debounced-low wire not yet recorded; because the
        // mask is sticky, a reconnected wire can never score twice.
        new_cuts                 = ~debounced & ~cut_mask_q;
        bad_wide                 = '0;
        bad_wide[N_WIRES-1:0]    = new_cuts & ~target_q;
        strike_sum               = PW'(strikes_q) + popcount(bad_wide);

        if (arm) begin
            state_d    = ST_ARMED;
            target_d   = target_mask;
            cut_mask_d = ~debounced;
            strikes_d  = '0;
        end else if (state_q == ST_ARMED) begin
            strikes_d   = (strike_sum >= PW'(MAX_STRIKES)) ? STRIKE_LIMIT
                                                           : SW'(strike_sum);
            cut_mask_d  = cut_mask_q | new_cuts;
            cut_pulse_d = |new_cuts;
            if (strikes_d == STRIKE_LIMIT) begin
                state_d = ST_EXPLODED;
            end else if ((target_q & ~cut_mask_d) == '0) begin
                state_d = ST_SOLVED;
            end
        end
    end

    // Round state and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            strikes_q   <= '0;
            cut_mask_q  <= '0;
            target_q    <= '0;
            cut_pulse_q <= 1'b0;
            solved_q    <= 1'b0;
            exploded_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            strikes_q   <= strikes_d;
            cut_mask_q  <= cut_mask_d;
            target_q    <= target_d;
            cut_pulse_q <= cut_pulse_d;
            solved_q    <= (state_d == ST_SOLVED);
            exploded_q  <= (state_d == ST_EXPLODED);
        end
    end

    assign led_solved   = solved_q;
    assign led_exploded = exploded_q;
    assign strikes      = strikes_q;
    assign cut_pulse    = cut_pulse_q;
    assign cut_mask     = cut_mask_q;

endmodule

// File: doc/wire_cut_checker.md
# wire_cut_checker

Parametrised wire-puzzle checker for the defusal game: tracks N physical wire inputs, decides on each newly cut wire whether it was a required cut or a mistake, counts strikes and reports solved or exploded. It replaces the single fixed-pattern LED check with a debounced, stateful round controller. It sits between the board wire-sense pins and the game's top-level LED and outcome logic.

## Interface
- N_WIRES, 6, number of wire inputs (1..16)
- MAX_STRIKES, 3, wrong cuts that end the round as exploded (1..15)
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a wire change is accepted (>=1)
- SW = $clog2(MAX_STRIKES+1), strike counter width (derived, not overridable)

- CLK  in  1  system clock, all logic on posedge
- RESET  in  1  synchronous, active-high reset
- wire_in  in  N_WIRES  raw wire sense, 1 = intact, 0 = cut; asynchronous to CLK
- target_mask  in  N_WIRES  wires that must be cut; sampled only on arm
- arm  in  1  one-cycle pulse that starts a round
- led_solved  out  1  high while in SOLVED
- led_exploded  out  1  high while in EXPLODED
- strikes  out  SW  wrong-cut count this round
- cut_pulse  out  1  one-cycle pulse on any accepted new cut while ARMED
- cut_mask  out  N_WIRES  wires registered as cut this round (sticky)

## Operation
- Input path per wire: 2-flop synchroniser, then debouncer; debounced value changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- New cut on wire i: debounced bit falls 1->0 while cut_mask[i]=0. Re-connection (0->1) is ignored; cut_mask never clears except on arm or RESET.
- States: IDLE, ARMED, SOLVED, EXPLODED.
- IDLE: arm -> ARMED; latch target_mask; cut_mask <= ~debounced (wires already cut at arm are pre-cut, not scored); strikes <= 0.
- ARMED: for the set C of new cuts this cycle: good = C & target, bad = C & ~target. strikes <= min(strikes + popcount(bad), MAX_STRIKES). cut_mask |= C. cut_pulse = (C != 0).
- ARMED -> EXPLODED when updated strikes == MAX_STRIKES; else -> SOLVED when (latched target & ~updated cut_mask) == 0. Explosion wins on simultaneous events.
- Target mask of 0, or all target wires already cut at arm: enter ARMED, then SOLVED on the following cycle.
- SOLVED / EXPLODED: terminal; further cuts ignored (no cut_pulse, no strike change); arm starts a new round as from IDLE.
- arm while ARMED: restarts the round (same actions as in IDLE).
- RESET: state IDLE, strikes 0, cut_mask 0, cut_pulse 0, led_solved 0, led_exploded 0, synchroniser and debounce flops to 1 (intact), counters 0. RESET mid-round discards the round.

## Timing
- All outputs registered; no combinational input-to-output path.
- Latency raw wire edge -> cut_pulse/strikes/cut_mask update: exactly DEBOUNCE_CYCLES + 3 cycles for a clean edge.
- led_solved/led_exploded assert on the same edge as the strikes/cut_mask update that causes them.
- arm -> state ARMED, strikes 0 visible the next cycle.

## Structure
- Package wire_cut_pkg: state enum (IDLE, ARMED, SOLVED, EXPLODED), popcount function.
- Sub-module wire_debouncer (one wire: synchroniser + counter, parameter DEBOUNCE_CYCLES), instantiated N_WIRES times via generate.

## Test plan
(bench uses N_WIRES=6, MAX_STRIKES=3, DEBOUNCE_CYCLES=4)
- arm with target 6'b000101, cut wires 0 then 2 cleanly -> two cut_pulses, strikes 0, led_solved=1 exactly 7 cycles after the wire-2 edge.
- Target 6'b000001, cut wires 1, 3, 4 one at a time -> strikes 1,2,3, led_exploded on the third; later cut of wire 0 gives no pulse.
- Wires 1 and 0 cut on the same cycle, target 6'b000001, strikes already 2 -> EXPLODED, not SOLVED; strikes=3.
- Bounce wire 0 low for 3 cycles then high -> no cut_pulse, cut_mask unchanged; reconnect a cut wire -> no effect.
- Wire 5 cut before arm, target 6'b100000 -> SOLVED one cycle after ARMED, strikes 0.
- RESET asserted mid-round with strikes=2 -> next cycle IDLE, strikes 0, all LEDs 0, cut_mask 0.
